// File: rtl/lsu_pkg.sv
// lsu_pkg: definitions shared by the data-memory scheduler.
//   lsu_state_e    scheduler FSM encoding
//   DATA_W, BE_W   memory data and byte-enable widths
//   BYP_*          bypass layout {valid, rd, data}, data at bit 0
//   kill_hit       tag-indexed branch-kill test, operands zero-padded to
//                  KILL_TAG_MAX_W / KILL_VEC_MAX_W
//   cnt_width      width of a counter that must hold 0..max
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_LD  = 3'd1,
    ST_REQ_ST  = 3'd2,
    ST_WAIT_LD = 3'd3,
    ST_WAIT_ST = 3'd4
  } lsu_state_e;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Bypass word: data in [DATA_W-1:0], rd directly above it, valid on top.
  localparam int BYP_DATA_LSB = 0;
  localparam int BYP_RD_LSB   = DATA_W;

  // Kill vectors and tags from any backend unit are zero-padded to these
  // widths so one predicate covers every branch-tag width up to 8 bits.
  localparam int KILL_TAG_MAX_W = 8;
  localparam int KILL_VEC_MAX_W = 1 << KILL_TAG_MAX_W;

  function automatic logic kill_hit(input logic [KILL_VEC_MAX_W-1:0] kill_vec,
                                    input logic [KILL_TAG_MAX_W-1:0] tag);
    return kill_vec[tag];
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lsu_prio_arb.sv
// lsu_prio_arb: store/load priority decision for the memory scheduler and
// the saturating count of load grants taken while a store was waiting.
//   clk, rst   clock, synchronous active-high reset
//   arb_en     scheduler is idle; decision is used and the count may move
//   ld_valid   load head request
//   st_valid   committed-store head request
//   st_full    store queue full, store forced ahead
//   ld_win     load wins this cycle
//   st_win     store wins this cycle
module lsu_prio_arb
  import lsu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ld_valid,
  input  logic st_valid,
  input  logic st_full,
  output logic ld_win,
  output logic st_win
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_MAX));
  assign st_win  = st_valid && (st_full || starved || !ld_valid);
  assign ld_win  = ld_valid && !st_win;

  // A load taken at request time and then dropped by branch kill still
  // counts: the store was held off that cycle all the same.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (arb_en) begin
      if (st_win) begin
        starve_q <= '0;
      end else if (ld_win && st_valid && !starved) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lsu_mem_sched.sv
// lsu_mem_sched: single data-memory port scheduler behind the LSU.
// Picks between the LAQ head (load) and the committed SAQ head (store),
// keeps one access outstanding, and drops or squashes loads hit by branch
// kill. Stores are already committed and are never killed.
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_ld_* / o_ld_ready         load head request and consume pulse
//   i_st_* / o_st_ready         store head request and consume pulse
//   i_brkill                    one kill bit per branch tag
//   o_mem_* / i_mem_*           memory request, grant and response
//   o_valid, o_addr, o_data     registered load writeback
//   o_bypass                    {valid, rd, data} straight from the response
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | arbitrating; winner latched, its ready pulses
// ST_REQ_LD  | load request on the port, waiting for grant
// ST_REQ_ST  | store request on the port, waiting for grant
// ST_WAIT_LD | load granted, waiting for read data
// ST_WAIT_ST | store granted, waiting for write ack
module lsu_mem_sched
  import lsu_pkg::*;
#(
  parameter int WIDTH_MEM  = 4,
  parameter int WIDTH_BRM  = 4,
  parameter int WIDTH_REG  = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ld_valid,
  output logic                        o_ld_ready,
  input  logic [WIDTH_MEM-1:0]        i_ld_addr,
  input  logic [WIDTH_REG-1:0]        i_ld_rd,
  input  logic [WIDTH_BRM-1:0]        i_ld_brtag,
  input  logic                        i_st_valid,
  output logic                        o_st_ready,
  input  logic [WIDTH_MEM-1:0]        i_st_addr,
  input  logic [DATA_W-1:0]           i_st_data,
  input  logic [BE_W-1:0]             i_st_be,
  input  logic                        i_st_full,
  input  logic [(1<<WIDTH_BRM)-1:0]   i_brkill,
  output logic                        o_mem_req,
  output logic                        o_mem_we,
  output logic [WIDTH_MEM-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  output logic [BE_W-1:0]             o_mem_be,
  input  logic                        i_mem_gnt,
  input  logic                        i_mem_rvalid,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  output logic                        o_valid,
  output logic [WIDTH_REG-1:0]        o_addr,
  output logic [DATA_W-1:0]           o_data,
  output logic [DATA_W+WIDTH_REG:0]   o_bypass
);

  lsu_state_e state_q, state_d;

  logic [WIDTH_MEM-1:0] h_addr;
  logic [WIDTH_REG-1:0] h_rd;
  logic [WIDTH_BRM-1:0] h_tag;
  logic [DATA_W-1:0]    h_wdata;
  logic [BE_W-1:0]      h_be;
  logic                 kill_q;

  logic ld_win, st_win;
  logic ld_ready, st_ready, ld_accept, st_accept;
  logic mem_req, mem_we, ld_rsp, ld_rsp_valid;
  logic head_killed, held_killed;

  logic [KILL_VEC_MAX_W-1:0] kill_ext;
  logic [KILL_TAG_MAX_W-1:0] head_tag_ext, held_tag_ext;

  always_comb begin
    kill_ext     = '0;
    head_tag_ext = '0;
    held_tag_ext = '0;
    kill_ext[(1<<WIDTH_BRM)-1:0] = i_brkill;
    head_tag_ext[WIDTH_BRM-1:0]  = i_ld_brtag;
    held_tag_ext[WIDTH_BRM-1:0]  = h_tag;
  end

  assign head_killed = kill_hit(kill_ext, head_tag_ext);
  assign held_killed = kill_hit(kill_ext, held_tag_ext);

  lsu_prio_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (i_clk),
    .rst      (i_rst),
    .arb_en   (state_q == ST_IDLE),
    .ld_valid (i_ld_valid),
    .st_valid (i_st_valid),
    .st_full  (i_st_full),
    .ld_win   (ld_win),
    .st_win   (st_win)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    st_ready  = 1'b0;
    ld_accept = 1'b0;
    st_accept = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ld_rsp    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (st_win) begin
          st_ready  = 1'b1;
          st_accept = 1'b1;
          state_d   = ST_REQ_ST;
        end else if (ld_win) begin
          // A load already under kill is consumed and dropped; the port
          // stays free and the store waits for the next decision.
          ld_ready = 1'b1;
          if (!head_killed) begin
            ld_accept = 1'b1;
            state_d   = ST_REQ_LD;
          end
        end
      end
      ST_REQ_LD: begin
        mem_req = 1'b1;
        if (i_mem_gnt) state_d = ST_WAIT_LD;
      end
      ST_REQ_ST: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (i_mem_gnt) state_d = ST_WAIT_ST;
      end
      ST_WAIT_LD: begin
        if (i_mem_rvalid) begin
          ld_rsp  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ST: begin
        if (i_mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_addr  <= '0;
      h_rd    <= '0;
      h_tag   <= '0;
      h_wdata <= '0;
      h_be    <= '0;
    end else if (ld_accept) begin
      h_addr <= i_ld_addr;
      h_rd   <= i_ld_rd;
      h_tag  <= i_ld_brtag;
    end else if (st_accept) begin
      h_addr  <= i_st_addr;
      h_wdata <= i_st_data;
      h_be    <= i_st_be;
    end
  end

  // Sticky kill for the load in flight; a kill seen in the response cycle
  // itself is folded in combinationally through held_killed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      kill_q <= 1'b0;
    end else if ((state_q == ST_REQ_LD) || (state_q == ST_WAIT_LD)) begin
      kill_q <= ld_rsp ? 1'b0 : (kill_q | held_killed);
    end else begin
      kill_q <= 1'b0;
    end
  end

  assign ld_rsp_valid = ld_rsp && !kill_q && !held_killed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
    end else begin
      o_valid <= ld_rsp_valid;
      if (ld_rsp_valid) begin
        o_addr <= h_rd;
        o_data <= i_mem_rdata;
      end
    end
  end

  // Combinational outputs are forced low while reset is held so nothing
  // leaks out before the state register has been cleared.
  always_comb begin
    o_bypass = '0;
    if (ld_rsp && !i_rst) begin
      o_bypass[BYP_DATA_LSB +: DATA_W]  = i_mem_rdata;
      o_bypass[BYP_RD_LSB +: WIDTH_REG] = h_rd;
      o_bypass[DATA_W+WIDTH_REG]        = ld_rsp_valid;
    end
  end

  assign o_ld_ready  = ld_ready && !i_rst;
  assign o_st_ready  = st_ready && !i_rst;
  assign o_mem_req   = mem_req && !i_rst;
  assign o_mem_we    = mem_we && !i_rst;
  assign o_mem_addr  = o_mem_req ? h_addr : '0;
  assign o_mem_wdata = o_mem_we ? h_wdata : '0;
  assign o_mem_be    = o_mem_we ? h_be : '0;

endmodule

// File: tb/tb_lsu_mem_sched.sv
// tb_lsu_mem_sched: self-checking bench for lsu_mem_sched. Loads and stores
// sit in queues whose heads drive the DUT; a transaction-level model picks
// the expected service order, request fields and writeback results.
module tb_lsu_mem_sched;

  localparam int WIDTH_MEM  = 4;
  localparam int WIDTH_BRM  = 4;
  localparam int WIDTH_REG  = 5;
  localparam int STARVE_MAX = 4;
  localparam int BYP_W      = 33 + WIDTH_REG;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic                   i_ld_valid, o_ld_ready;
  logic [WIDTH_MEM-1:0]   i_ld_addr;
  logic [WIDTH_REG-1:0]   i_ld_rd;
  logic [WIDTH_BRM-1:0]   i_ld_brtag;
  logic                   i_st_valid, o_st_ready;
  logic [WIDTH_MEM-1:0]   i_st_addr;
  logic [31:0]            i_st_data;
  logic [3:0]             i_st_be;
  logic                   i_st_full;
  logic [15:0]            i_brkill;
  logic                   o_mem_req, o_mem_we;
  logic [WIDTH_MEM-1:0]   o_mem_addr;
  logic [31:0]            o_mem_wdata;
  logic [3:0]             o_mem_be;
  logic                   i_mem_gnt, i_mem_rvalid;
  logic [31:0]            i_mem_rdata;
  logic                   o_valid;
  logic [WIDTH_REG-1:0]   o_addr;
  logic [31:0]            o_data;
  logic [BYP_W-1:0]       o_bypass;

  always #5 i_clk = ~i_clk;

  lsu_mem_sched #(
    .WIDTH_MEM(WIDTH_MEM), .WIDTH_BRM(WIDTH_BRM),
    .WIDTH_REG(WIDTH_REG), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_addr(i_ld_addr),
    .i_ld_rd(i_ld_rd), .i_ld_brtag(i_ld_brtag),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_addr(i_st_addr),
    .i_st_data(i_st_data), .i_st_be(i_st_be), .i_st_full(i_st_full),
    .i_brkill(i_brkill),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_valid(o_valid), .o_addr(o_addr), .o_data(o_data), .o_bypass(o_bypass)
  );

  typedef struct {
    logic [WIDTH_MEM-1:0] addr;
    logic [WIDTH_REG-1:0] rd;
    logic [WIDTH_BRM-1:0] tag;
    logic [31:0]          rdata;
    int                   kill_at;   // busy-cycle index carrying the kill, -1 = none
    bit                   kill_req;  // killed in the cycle it would be accepted
  } ld_t;

  typedef struct {
    logic [WIDTH_MEM-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           be;
    bit                   full;
  } st_t;

  ld_t ld_q[$];
  st_t st_q[$];

  int n_cmp = 0;
  int n_err = 0;
  bit rand_dly;
  int gnt_dly, rv_dly;
  logic                 exp_valid;
  logic [WIDTH_REG-1:0] exp_addr;
  logic [31:0]          exp_data;
  string glog;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_heads();
    i_ld_valid = (ld_q.size() > 0);
    i_st_valid = (st_q.size() > 0);
    i_ld_addr = '0; i_ld_rd = '0; i_ld_brtag = '0;
    i_st_addr = '0; i_st_data = '0; i_st_be = '0; i_st_full = 1'b0;
    if (ld_q.size() > 0) begin
      i_ld_addr = ld_q[0].addr; i_ld_rd = ld_q[0].rd; i_ld_brtag = ld_q[0].tag;
    end
    if (st_q.size() > 0) begin
      i_st_addr = st_q[0].addr; i_st_data = st_q[0].data;
      i_st_be = st_q[0].be; i_st_full = st_q[0].full;
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_ld_valid = 0; i_st_valid = 0; i_st_full = 0; i_brkill = '0;
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    i_ld_addr = '0; i_ld_rd = '0; i_ld_brtag = '0;
    i_st_addr = '0; i_st_data = '0; i_st_be = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_valid = 1'b0; exp_addr = '0; exp_data = '0;
  endtask

  // Serves both queues to completion; one outer iteration per arbitration.
  task automatic run_ops(string name);
    int   starve = 0;
    bit   ldp, stp, st_win, drop, is_ld, killed, rsp;
    int   d, r, idx;
    ld_t  cl;
    st_t  cs;
    logic [15:0] kv;
    logic [31:0] rdat;
    logic [BYP_W-1:0] exp_byp;
    glog = "";
    while (ld_q.size() > 0 || st_q.size() > 0) begin
      ldp = (ld_q.size() > 0);
      stp = (st_q.size() > 0);
      st_win = 1'b0;
      if (stp) st_win = st_q[0].full || (starve == STARVE_MAX) || !ldp;
      drop = 1'b0;
      if (!st_win) drop = ld_q[0].kill_req;

      @(negedge i_clk);
      drive_heads();
      i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'($urandom_range(0, 1));
      i_mem_rdata = $urandom;
      i_brkill = drop ? (16'h1 << ld_q[0].tag) : 16'h0;
      #1;
      n_cmp++;
      if ({o_valid, o_addr, o_data} !== {exp_valid, exp_addr, exp_data}) begin
        n_err++;
        $display("FAIL %s wb_idle: got v=%0b a=%0d d=%h want v=%0b a=%0d d=%h",
                 name, o_valid, o_addr, o_data, exp_valid, exp_addr, exp_data);
      end
      n_cmp++;
      if ({o_ld_ready, o_st_ready, o_mem_req, o_bypass[BYP_W-1]} !== {!st_win, st_win, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL %s arb: got ldr=%0b str=%0b req=%0b byp=%0b want ldr=%0b str=%0b req=0 byp=0",
                 name, o_ld_ready, o_st_ready, o_mem_req, o_bypass[BYP_W-1], !st_win, st_win);
      end
      exp_valid = 1'b0;
      glog = {glog, st_win ? "S" : (drop ? "K" : "L")};
      if (st_win) starve = 0;
      else if (stp && starve < STARVE_MAX) starve++;
      is_ld = !st_win;
      if (st_win) cs = st_q.pop_front();
      else        cl = ld_q.pop_front();
      if (drop) continue;

      d = rand_dly ? int'($urandom_range(0, 2)) : gnt_dly;
      r = rand_dly ? int'($urandom_range(0, 2)) : rv_dly;
      idx = 0;
      killed = 1'b0;
      for (int c = 0; c <= d; c++) begin
        @(negedge i_clk);
        drive_heads();
        i_mem_gnt = (c == d);
        i_mem_rvalid = 1'($urandom_range(0, 1));
        i_mem_rdata = $urandom;
        kv = 16'($urandom);
        if (is_ld) begin
          kv[cl.tag] = (idx == cl.kill_at);
          killed = killed | kv[cl.tag];
        end
        i_brkill = kv;
        #1;
        n_cmp++;
        if ({o_valid, o_addr, o_data} !== {exp_valid, exp_addr, exp_data}) begin
          n_err++;
          $display("FAIL %s wb_req: got v=%0b a=%0d d=%h want v=%0b a=%0d d=%h",
                   name, o_valid, o_addr, o_data, exp_valid, exp_addr, exp_data);
        end
        n_cmp++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_ld_ready, o_st_ready, o_bypass[BYP_W-1]} !==
            {1'b1, !is_ld, is_ld ? cl.addr : cs.addr, 3'b000}) begin
          n_err++;
          $display("FAIL %s req: got req=%0b we=%0b addr=%h ldr=%0b str=%0b byp=%0b want req=1 we=%0b addr=%h",
                   name, o_mem_req, o_mem_we, o_mem_addr, o_ld_ready, o_st_ready,
                   o_bypass[BYP_W-1], !is_ld, is_ld ? cl.addr : cs.addr);
        end
        if (!is_ld) begin
          n_cmp++;
          if ({o_mem_wdata, o_mem_be} !== {cs.data, cs.be}) begin
            n_err++;
            $display("FAIL %s st_fields: got wdata=%h be=%h want wdata=%h be=%h",
                     name, o_mem_wdata, o_mem_be, cs.data, cs.be);
          end
        end
        exp_valid = 1'b0;
        idx++;
      end

      for (int c = 0; c <= r; c++) begin
        rsp = (c == r);
        @(negedge i_clk);
        drive_heads();
        i_mem_gnt = 1'b0;
        i_mem_rvalid = rsp;
        rdat = (is_ld && rsp) ? cl.rdata : $urandom;
        i_mem_rdata = rdat;
        kv = 16'($urandom);
        if (is_ld) begin
          kv[cl.tag] = (idx == cl.kill_at);
          killed = killed | kv[cl.tag];
        end
        i_brkill = kv;
        #1;
        n_cmp++;
        if ({o_valid, o_addr, o_data} !== {exp_valid, exp_addr, exp_data}) begin
          n_err++;
          $display("FAIL %s wb_wait: got v=%0b a=%0d d=%h want v=%0b a=%0d d=%h",
                   name, o_valid, o_addr, o_data, exp_valid, exp_addr, exp_data);
        end
        n_cmp++;
        if ({o_mem_req, o_ld_ready, o_st_ready, o_bypass[BYP_W-1]} !==
            {3'b000, is_ld && rsp && !killed}) begin
          n_err++;
          $display("FAIL %s wait: got req=%0b ldr=%0b str=%0b bypv=%0b want req=0 ldr=0 str=0 bypv=%0b",
                   name, o_mem_req, o_ld_ready, o_st_ready, o_bypass[BYP_W-1], is_ld && rsp && !killed);
        end
        if (is_ld && rsp) begin
          exp_byp = {!killed, cl.rd, rdat};
          n_cmp++;
          if (o_bypass !== exp_byp) begin
            n_err++;
            $display("FAIL %s bypass: got %h want %h", name, o_bypass, exp_byp);
          end
        end
        exp_valid = is_ld && rsp && !killed;
        if (exp_valid) begin
          exp_addr = cl.rd;
          exp_data = rdat;
        end
        idx++;
      end
    end

    @(negedge i_clk);
    drive_heads();
    i_mem_gnt = 0; i_mem_rvalid = 0; i_brkill = '0;
    #1;
    n_cmp++;
    if ({o_valid, o_addr, o_data} !== {exp_valid, exp_addr, exp_data}) begin
      n_err++;
      $display("FAIL %s wb_last: got v=%0b a=%0d d=%h want v=%0b a=%0d d=%h",
               name, o_valid, o_addr, o_data, exp_valid, exp_addr, exp_data);
    end
    exp_valid = 1'b0;
    $display("%s grant order %s", name, glog);
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_ld_valid = 1; i_st_valid = 1; i_st_full = 1; i_brkill = '0;
    i_ld_addr = 4'h3; i_ld_rd = 5'd9; i_ld_brtag = 4'd1;
    i_st_addr = 4'h5; i_st_data = 32'h12345678; i_st_be = 4'hF;
    i_mem_gnt = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hFFFF0000;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    n_cmp++;
    if ({o_ld_ready, o_st_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
         o_valid, o_addr, o_data, o_bypass} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ldr=%0b str=%0b req=%0b we=%0b v=%0b byp=%h want all 0",
               o_ld_ready, o_st_ready, o_mem_req, o_mem_we, o_valid, o_bypass);
    end
    do_reset();
  endtask

  task automatic test_load_only();
    do_reset();
    rand_dly = 0; gnt_dly = 0; rv_dly = 0;
    ld_q.push_back('{addr: 4'h4, rd: 5'd7, tag: 4'd0, rdata: 32'hDEADBEEF, kill_at: -1, kill_req: 1'b0});
    run_ops("load_only");
  endtask

  task automatic test_store_only();
    do_reset();
    rand_dly = 0; gnt_dly = 2; rv_dly = 1;
    st_q.push_back('{addr: 4'h8, data: 32'h11223344, be: 4'hF, full: 1'b0});
    run_ops("store_only");
  endtask

  task automatic test_starvation();
    do_reset();
    rand_dly = 0; gnt_dly = 0; rv_dly = 0;
    for (int i = 0; i < 9; i++)
      ld_q.push_back('{addr: 4'(i), rd: 5'(i + 1), tag: 4'(i), rdata: 32'hA000_0000 + 32'(i), kill_at: -1, kill_req: 1'b0});
    for (int i = 0; i < 2; i++)
      st_q.push_back('{addr: 4'(8 + i), data: 32'h5000_0000 + 32'(i), be: 4'h3, full: 1'b0});
    run_ops("starvation");
    n_cmp++;
    if (glog != "LLLLSLLLLSL") begin
      n_err++;
      $display("FAIL starve_order: got %s want LLLLSLLLLSL", glog);
    end
  endtask

  task automatic test_st_full();
    do_reset();
    rand_dly = 0; gnt_dly = 1; rv_dly = 0;
    ld_q.push_back('{addr: 4'h2, rd: 5'd3, tag: 4'd4, rdata: 32'h0BADF00D, kill_at: -1, kill_req: 1'b0});
    st_q.push_back('{addr: 4'hC, data: 32'hCAFEBABE, be: 4'h5, full: 1'b1});
    run_ops("st_full");
    n_cmp++;
    if (glog != "SL") begin
      n_err++;
      $display("FAIL st_full_order: got %s want SL", glog);
    end
  endtask

  task automatic test_kill_in_flight();
    do_reset();
    rand_dly = 0; gnt_dly = 0; rv_dly = 2;
    // killed one cycle after the grant; the follow-up load with the same
    // tag must come back clean once the kill flag has cleared
    ld_q.push_back('{addr: 4'h6, rd: 5'd12, tag: 4'd2, rdata: 32'h13579BDF, kill_at: 1, kill_req: 1'b0});
    ld_q.push_back('{addr: 4'h7, rd: 5'd13, tag: 4'd2, rdata: 32'h2468ACE0, kill_at: -1, kill_req: 1'b0});
    run_ops("kill_in_flight");
  endtask

  task automatic test_kill_at_request();
    do_reset();
    rand_dly = 0; gnt_dly = 0; rv_dly = 0;
    ld_q.push_back('{addr: 4'h1, rd: 5'd20, tag: 4'd5, rdata: 32'h99999999, kill_at: -1, kill_req: 1'b1});
    ld_q.push_back('{addr: 4'h9, rd: 5'd21, tag: 4'd6, rdata: 32'h77777777, kill_at: -1, kill_req: 1'b0});
    run_ops("kill_at_request");
    n_cmp++;
    if (glog != "KL") begin
      n_err++;
      $display("FAIL kill_req_order: got %s want KL", glog);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    @(negedge i_clk);
    i_ld_valid = 1; i_ld_addr = 4'hA; i_ld_rd = 5'd30; i_ld_brtag = 4'd3;
    #1;
    n_cmp++;
    if (o_ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_wait_accept: got ldr=%0b want 1", o_ld_ready);
    end
    @(negedge i_clk);
    i_ld_valid = 0; i_mem_gnt = 1;
    @(negedge i_clk);
    i_mem_gnt = 0; i_rst = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D;
    #1;
    n_cmp++;
    if ({o_ld_ready, o_st_ready, o_mem_req, o_bypass} !== '0) begin
      n_err++;
      $display("FAIL rst_wait_during: got ldr=%0b str=%0b req=%0b byp=%h want 0",
               o_ld_ready, o_st_ready, o_mem_req, o_bypass);
    end
    @(negedge i_clk);
    i_rst = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hFEEDFACE;
    #1;
    n_cmp++;
    if ({o_mem_req, o_bypass, o_valid, o_addr, o_data} !== '0) begin
      n_err++;
      $display("FAIL rst_wait_after: got req=%0b byp=%h v=%0b a=%0d d=%h want 0",
               o_mem_req, o_bypass, o_valid, o_addr, o_data);
    end
    @(negedge i_clk);
    i_mem_rvalid = 0;
    #1;
    n_cmp++;
    if ({o_valid, o_addr, o_data} !== '0) begin
      n_err++;
      $display("FAIL rst_wait_wb: got v=%0b a=%0d d=%h want 0", o_valid, o_addr, o_data);
    end
    exp_valid = 0; exp_addr = '0; exp_data = '0;
    rand_dly = 0; gnt_dly = 0; rv_dly = 0;
    ld_q.push_back('{addr: 4'hB, rd: 5'd31, tag: 4'd7, rdata: 32'h31415926, kill_at: -1, kill_req: 1'b0});
    run_ops("after_reset");
  endtask

  task automatic test_random();
    do_reset();
    rand_dly = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1)
        ld_q.push_back('{addr: 4'($urandom), rd: 5'($urandom), tag: 4'($urandom),
                         rdata: $urandom,
                         kill_at: ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1,
                         kill_req: 1'b0});
      else
        st_q.push_back('{addr: 4'($urandom), data: $urandom, be: 4'($urandom),
                         full: ($urandom_range(0, 4) == 0)});
    end
    run_ops("random");
  endtask

  initial begin
    i_rst = 1'b1;
    i_ld_valid = 0; i_st_valid = 0; i_st_full = 0; i_brkill = '0;
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    i_ld_addr = '0; i_ld_rd = '0; i_ld_brtag = '0;
    i_st_addr = '0; i_st_data = '0; i_st_be = '0;
    test_reset();
    test_load_only();
    test_store_only();
    test_starvation();
    test_st_full();
    test_kill_in_flight();
    test_kill_at_request();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_sched.md
Name: lsu_mem_sched

Overview:
Scheduler for the single data-memory port behind the LSU. It arbitrates between load issue (LAQ head) and committed-store drain (SAQ head), tracks one outstanding access, and applies branch kill to in-flight loads. Load data goes out as a writeback and a bypass. Stores are never killed because they are already committed.

Parameters:
WIDTH_MEM, 4, data-memory byte-address width
WIDTH_BRM, 4, branch-tag width; the kill vector is 2**WIDTH_BRM bits
WIDTH_REG, 5, physical destination-register index width
STARVE_MAX, 4, consecutive load grants allowed while a store waits

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_ld_valid  in  1  LAQ head request valid
o_ld_ready  out  1  LAQ head consumed this cycle
i_ld_addr  in  WIDTH_MEM  load byte address
i_ld_rd  in  WIDTH_REG  load destination register
i_ld_brtag  in  WIDTH_BRM  load branch tag
i_st_valid  in  1  SAQ committed-store head valid
o_st_ready  out  1  SAQ head consumed this cycle
i_st_addr  in  WIDTH_MEM  store byte address
i_st_data  in  32  store data
i_st_be  in  4  store byte enables
i_st_full  in  1  SAQ full, forces store priority
i_brkill  in  2**WIDTH_BRM  branch-kill vector, one bit per tag
o_mem_req  out  1  memory request
o_mem_we  out  1  1 = write
o_mem_addr  out  WIDTH_MEM  memory address
o_mem_wdata  out  32  write data
o_mem_be  out  4  byte enables
i_mem_gnt  in  1  memory accepted the request this cycle
i_mem_rvalid  in  1  response for the outstanding access
i_mem_rdata  in  32  load data
o_valid  out  1  load writeback valid (registered)
o_addr  out  WIDTH_REG  writeback register
o_data  out  32  writeback data
o_bypass  out  33+WIDTH_REG  {valid, rd, data}, combinational from the response

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE, starve count=0, kill flag=0. All o_* outputs are 0, including o_ld_ready and o_st_ready. A response arriving during or after reset while in IDLE is ignored.
- FSM states: IDLE, REQ_LD, REQ_ST, WAIT_LD, WAIT_ST.
- IDLE arbitration, one decision per cycle:
  - Store wins if i_st_valid and any of: i_st_full, starve count == STARVE_MAX, or !i_ld_valid.
  - Otherwise load wins if i_ld_valid.
- Load-win bookkeeping: if a store was also valid, starve count +1, saturating at STARVE_MAX. A store grant clears the count.
- The winner is latched into holding regs and its ready pulses for 1 cycle in the same IDLE cycle. The FSM then goes to REQ_LD or REQ_ST.
- Load killed at request time: if i_brkill[i_ld_brtag]=1 in the IDLE cycle the load would win, it is consumed (o_ld_ready=1) and dropped. The FSM stays IDLE and the store is not granted that cycle.
- REQ_x: o_mem_req=1 with the held fields; o_mem_we=1 only in REQ_ST. The FSM stays until i_mem_gnt, then moves to WAIT_x. Request fields are stable while waiting for the grant.
- WAIT_LD: kill flag |= i_brkill[held brtag] every cycle from REQ_LD onward.
  - On i_mem_rvalid, the result is valid when the flag is clear and the tag is not being killed that same cycle.
  - o_bypass = {valid, held rd, i_mem_rdata} in that cycle.
  - o_valid/o_addr/o_data are registered the next cycle.
  - o_addr/o_data update only when valid; o_valid updates every cycle.
  - FSM returns to IDLE and the kill flag clears.
- WAIT_ST: on i_mem_rvalid (write ack), return to IDLE; no writeback.
- Minimum load latency: accept cycle, then grant, then a 1-cycle rvalid gives o_valid 3 cycles after the accept edge.
- Back-to-back: arbitration resumes in the cycle after the return to IDLE. There is at most one outstanding access.
- i_mem_rvalid outside WAIT_x is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - State encoding (IDLE, REQ_LD, REQ_ST, WAIT_LD, WAIT_ST).
  - Bypass field layout {valid, rd, data}.
  - The kill predicate, the same tag-indexed test used across the backend.
- Natural sub-module: lsu_prio_arb, the combinational store/load priority decision plus the saturating starve counter.

Test Plan:
- Load only: addr=0x4, rd=7, gnt next cycle, rvalid one cycle later with rdata=0xDEADBEEF -> bypass valid that cycle; next cycle o_valid=1, o_addr=7, o_data=0xDEADBEEF.
- Store only: addr=0x8, data=0x11223344, be=0xF -> o_mem_req=1, o_mem_we=1, be=0xF held until gnt; o_st_ready is 1 cycle; no o_valid.
- Starvation: loads always valid, store valid, STARVE_MAX=4 -> 4 load grants, then the store is granted, then the count returns to 0.
- i_st_full=1 with both valid -> store granted first.
- Kill in flight: load brtag=2, i_brkill=0x0004 one cycle after the grant; rvalid later -> o_bypass valid=0 and o_valid stays 0; the FSM returns to IDLE.
- Reset asserted in WAIT_LD, then rvalid the following cycle -> no o_valid, all outputs 0, state IDLE.
